// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one word-wide synchronous RAM port between instruction fetch and data
// load/store. Byte/halfword stores become read-modify-write sequences, sub-word
// load data is lane-selected and extended, and misaligned data accesses are
// flagged instead of reaching the RAM. RAM read data arrives one cycle after
// the read is issued.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   i_if_req/i_if_addr  fetch request and word address (bits [1:0] ignored)
//   o_if_gnt            fetch accepted this cycle (combinational)
//   o_if_rvalid/rdata   fetched word, one cycle after the grant
//   i_d_req/we/size/    data request: store/load, size (00 B, 01 H, 1x W),
//   i_d_unsigned/addr/    zero-extend flag, byte address, right-aligned
//   i_d_wdata             store data
//   o_d_gnt             data request accepted this cycle (combinational)
//   o_d_rvalid/rdata    formatted load data, one cycle after the grant
//   o_d_err             one-cycle pulse following a misaligned grant
//   o_ram_ena/rw/addr/  RAM command (rw: 0 = read, 1 = write), byte address
//   o_ram_wdata           and write word
//   i_ram_rdata         RAM read word, registered inside the RAM
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    // Instruction fetch
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic          o_if_gnt,
    output logic          o_if_rvalid,
    output logic [DW-1:0] o_if_rdata,
    // Data load/store
    input  logic          i_d_req,
    input  logic          i_d_we,
    input  logic [1:0]    i_d_size,
    input  logic          i_d_unsigned,
    input  logic [AW-1:0] i_d_addr,
    input  logic [DW-1:0] i_d_wdata,
    output logic          o_d_gnt,
    output logic          o_d_rvalid,
    output logic [DW-1:0] o_d_rdata,
    output logic          o_d_err,
    // RAM port
    output logic          o_ram_ena,
    output logic          o_ram_rw,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_wdata,
    input  logic [DW-1:0] i_ram_rdata
);

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StRmw,
        StErr
    } state_e;

    state_e        r_state;
    state_e        w_state_next;
    logic          r_last_owner;
    logic          w_last_owner_next;
    logic          r_rd_owner;
    logic          w_rd_owner_next;

    // Data request context, captured on every data grant
    logic [AW-1:0] r_addr;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic [15:0]   r_wdata;

    logic          w_accept;
    logic          w_pick_d;
    logic          w_if_gnt;
    logic          w_d_gnt;
    logic          w_misaligned;
    logic          w_ram_ena;
    logic [7:0]    w_lane_byte;
    logic [15:0]   w_lane_half;
    logic [DW-1:0] w_merged;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    // RMW owns the RAM port for its write cycle, so it is the only state that
    // cannot accept a new request. Grants are also held off during reset.
    assign w_accept = rst_n && (r_state != StRmw);

    // Data wins when alone, or when both request and IF went last.
    assign w_pick_d = i_d_req && (!i_if_req || (r_last_owner == OWN_IF));

    assign w_if_gnt = w_accept && i_if_req && !w_pick_d;
    assign w_d_gnt  = w_accept && w_pick_d;

    assign o_if_gnt = w_if_gnt;
    assign o_d_gnt  = w_d_gnt;

    // Size 11 behaves as a word access.
    assign w_misaligned = ((i_d_size == SZ_HALF) && i_d_addr[0]) ||
                          (i_d_size[1] && (i_d_addr[1:0] != 2'b00));

    // -------------------------------------------------------------------------
    // Load formatting: pick the addressed lane, then extend to 32 bits
    // -------------------------------------------------------------------------
    always_comb begin
        w_lane_byte = i_ram_rdata[7:0];
        unique case (r_addr[1:0])
            2'b00:   w_lane_byte = i_ram_rdata[7:0];
            2'b01:   w_lane_byte = i_ram_rdata[15:8];
            2'b10:   w_lane_byte = i_ram_rdata[23:16];
            default: w_lane_byte = i_ram_rdata[31:24];
        endcase
        w_lane_half = r_addr[1] ? i_ram_rdata[31:16] : i_ram_rdata[15:0];
    end

    always_comb begin
        o_d_rdata = i_ram_rdata;
        case (r_size)
            SZ_BYTE: o_d_rdata = {{24{!r_unsigned && w_lane_byte[7]}}, w_lane_byte};
            SZ_HALF: o_d_rdata = {{16{!r_unsigned && w_lane_half[15]}}, w_lane_half};
            default: o_d_rdata = i_ram_rdata;
        endcase
    end

    assign o_if_rdata = i_ram_rdata;

    // -------------------------------------------------------------------------
    // Store merge for the RMW write cycle; only byte/half stores get here
    // -------------------------------------------------------------------------
    always_comb begin
        w_merged = i_ram_rdata;
        if (r_size == SZ_BYTE) begin
            unique case (r_addr[1:0])
                2'b00:   w_merged[7:0]   = r_wdata[7:0];
                2'b01:   w_merged[15:8]  = r_wdata[7:0];
                2'b10:   w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merged[31:16] = r_wdata;
        end else begin
            w_merged[15:0] = r_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and RAM command
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next      = StIdle;
        w_last_owner_next = r_last_owner;
        w_rd_owner_next   = r_rd_owner;
        w_ram_ena         = 1'b0;
        o_ram_rw          = MEM_READ;
        o_ram_addr        = i_if_addr;
        o_ram_wdata       = i_d_wdata;

        if (r_state == StRmw) begin
            w_ram_ena    = 1'b1;
            o_ram_rw     = MEM_WRITE;
            o_ram_addr   = r_addr;
            o_ram_wdata  = w_merged;
            w_state_next = StIdle;
        end else if (w_if_gnt) begin
            w_ram_ena         = 1'b1;
            o_ram_rw          = MEM_READ;
            o_ram_addr        = i_if_addr;
            w_last_owner_next = OWN_IF;
            w_rd_owner_next   = OWN_IF;
            w_state_next      = StRdWait;
        end else if (w_d_gnt) begin
            w_last_owner_next = OWN_D;
            o_ram_addr        = i_d_addr;
            if (w_misaligned) begin
                // Granted so the requester moves on, but the RAM is untouched.
                w_state_next = StErr;
            end else if (!i_d_we) begin
                w_ram_ena       = 1'b1;
                o_ram_rw        = MEM_READ;
                w_rd_owner_next = OWN_D;
                w_state_next    = StRdWait;
            end else if (i_d_size[1]) begin
                w_ram_ena    = 1'b1;
                o_ram_rw     = MEM_WRITE;
                o_ram_wdata  = i_d_wdata;
                w_state_next = StIdle;
            end else begin
                // Sub-word store: fetch the old word first, merge next cycle.
                w_ram_ena    = 1'b1;
                o_ram_rw     = MEM_READ;
                w_state_next = StRmw;
            end
        end
    end

    assign o_ram_ena = w_ram_ena && rst_n;

    assign o_if_rvalid = (r_state == StRdWait) && (r_rd_owner == OWN_IF);
    assign o_d_rvalid  = (r_state == StRdWait) && (r_rd_owner == OWN_D);
    assign o_d_err     = (r_state == StErr);

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_last_owner <= OWN_IF;
            r_rd_owner   <= OWN_IF;
        end else begin
            r_state      <= w_state_next;
            r_last_owner <= w_last_owner_next;
            r_rd_owner   <= w_rd_owner_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
        end else if (w_d_gnt) begin
            r_addr     <= i_d_addr;
            r_size     <= i_d_size;
            r_unsigned <= i_d_unsigned;
            r_wdata    <= i_d_wdata[15:0];
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the core and the word-wide synchronous RAM; shares a single RAM port between instruction fetch and data load/store.
- Converts byte/halfword stores into read-modify-write sequences and formats sub-word load data.
- Flags misaligned data accesses.
- RAM read data arrives one cycle after the read is issued.

Parameters:
- AW, 32, address width in bytes; the RAM consumes addr[AW-1:2].
- DW, 32, data width; fixed at 32.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request
- if_addr  in  AW  fetch byte address; word aligned, bits [1:0] ignored
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DW  fetched word
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word
- d_unsigned  in  1  zero-extend sub-word loads
- d_addr  in  AW  data byte address
- d_wdata  in  DW  store data, right-aligned
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  load data valid
- d_rdata  out  DW  formatted load data
- d_err  out  1  misaligned-access pulse
- ram_ena  out  1  RAM enable
- ram_rw  out  1  MEM_READ / MEM_WRITE encoding from the common definitions
- ram_addr  out  AW  RAM byte address
- ram_wdata  out  DW  RAM write word
- ram_rdata  in  DW  RAM read word, registered inside the RAM

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; last_owner = IF; if_rvalid, d_rvalid, d_err = 0.
  - While rst_n is low, if_gnt, d_gnt and ram_ena are forced to 0.
- States: IDLE, RD_WAIT, RMW, ERR.
- Accepting states are IDLE, RD_WAIT and ERR; only these may grant. RMW never grants.
- Arbitration (accepting states only):
  - Only one requester pending: it wins.
  - Both pending: the requester not equal to last_owner wins (round-robin).
  - last_owner updates on every grant.
- Fetch grant:
  - Same cycle: ram_ena = 1, ram_rw = READ, ram_addr = if_addr.
  - Owner IF latched; next state RD_WAIT.
- Data load grant, aligned:
  - Same cycle: RAM read at d_addr.
  - Latch addr[1:0], size and unsigned; next state RD_WAIT.
- Data word store grant, aligned:
  - Same cycle: ram_ena = 1, ram_rw = WRITE, ram_wdata = d_wdata.
  - Done; next state IDLE. No rvalid is produced.
- Data byte/half store grant, aligned:
  - Same cycle: RAM read at d_addr.
  - Latch addr, wdata and size; next state RMW.
- Misaligned access: half with addr[0] = 1, or word with addr[1:0] != 0.
  - Granted, but the RAM is not enabled.
  - Next state ERR; d_err = 1 for exactly the ERR cycle.
  - No rvalid is produced.
- RD_WAIT:
  - The owner's rvalid = 1 for this one cycle.
  - if_rdata = ram_rdata.
  - d_rdata = selected lane (little-endian, lane = addr[1:0]) shifted to bit 0, then sign- or zero-extended to 32 bits.
  - A new grant in this same cycle is allowed, giving 1 access/cycle back-to-back reads.
- RMW:
  - Merge latched wdata into ram_rdata:
    - byte: lane addr[1:0] receives wdata[7:0].
    - half: bits [15:0] or [31:16] (selected by addr[1]) receive wdata[15:0].
  - Issue ram_ena = 1, ram_rw = WRITE at the latched address; next state IDLE.
- Next state when no grant: IDLE, from IDLE, RD_WAIT or ERR.
- Latency:
  - Read: data 1 cycle after grant.
  - Word store: 1 cycle.
  - Sub-word store: 2 RAM cycles; the requester can next be granted 2 cycles after its grant.
- Requester rule: hold req, addr, size and wdata stable until the gnt cycle. Values are sampled only in the gnt cycle.
- Reset mid-RMW: the write is abandoned and RAM contents are unchanged. Reset mid-RD_WAIT: no rvalid is produced.
- ram_addr, ram_rw and ram_wdata are don't-care when ram_ena = 0.

Test Plan:
- Fetch only: if_req = 1, addrs 0x0, 0x4, 0x8 on consecutive cycles, RAM preloaded with 0x11111111, 0x22222222, 0x33333333 -> if_gnt every cycle; if_rvalid on cycles 1–3 with those words in order.
- Contention: if_req and d_req held high, loads only -> grants alternate D, IF, D, IF… (data first after reset); one rvalid per cycle, each returning its owner's data.
- Sub-word loads: word 0x8000F07F at 0x10:
  - LB at 0x10 -> 0x0000007F.
  - LB at 0x11 -> 0xFFFFFFF0.
  - LBU at 0x11 -> 0x000000F0.
  - LH at 0x12 -> 0xFFFF8000.
  - LHU at 0x12 -> 0x00008000.
- RMW store: word 0xAABBCCDD at 0x20; SB 0x5A at 0x21, then SH 0x1234 at 0x22 -> final word 0x12345ADD. Each SB/SH shows a RAM read then a RAM write on the next cycle; no grant during the RMW cycle.
- Misaligned: LW at 0x1 and SH at 0x3 -> d_gnt asserted, ram_ena stays 0, d_err pulses 1 cycle later, d_rvalid stays 0, RAM unchanged.
- Reset in RMW: drop rst_n during the RMW cycle of an SB -> outputs go to reset values immediately; RAM word unchanged; after release, a fresh fetch is granted normally.
